// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-level UART transmitter between N_REQ requesters.
// The grant stays locked to one requester from its first byte until its last byte has gone out.
module uart_tx_arbiter #(
    parameter int  GRANT_W      = 2,
    parameter int  GAP_CYCLES   = 5208,
    parameter int  LOCK_TIMEOUT = 50_000_000,
    parameter int  ACK_TIMEOUT  = 15,
    localparam int N_REQ        = 2**GRANT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 active,
    output logic                 lock_err,
    output logic                 ack_err
);
    localparam int GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int LOCK_LAST = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;
    localparam int ACK_LAST  = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
    localparam int TMO_MAX   = (LOCK_LAST > ACK_LAST) ? LOCK_LAST : ACK_LAST;
    localparam int GAP_W     = ($clog2(GAP_LAST + 1) > 13) ? $clog2(GAP_LAST + 1) : 13;
    localparam int TMO_W     = ($clog2(TMO_MAX + 1) > 26) ? $clog2(TMO_MAX + 1) : 26;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, GAP} state_t;

    state_t             state, state_nxt;
    logic [GRANT_W-1:0] rr_ptr, rr_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic               last_reg, last_nxt;
    logic               tx_start_nxt, active_nxt, lock_err_nxt, ack_err_nxt;
    logic [7:0]         tx_data_nxt;
    logic [GRANT_W-1:0] grant_nxt;
    logic               win_found;
    logic [GRANT_W-1:0] win_id, cand;
    logic               handshake, lock_expired, ack_expired, gap_expired;
    logic [7:0]         sel_data;

    assign handshake    = req_valid[grant_id];
    assign sel_data     = req_data[{grant_id, 3'b000} +: 8];
    assign lock_expired = (tmo_cnt == TMO_W'(LOCK_LAST));
    assign ack_expired  = (tmo_cnt >= TMO_W'(ACK_LAST));
    assign gap_expired  = (gap_cnt == GAP_W'(GAP_LAST));

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (state == LOAD) && (grant_id == GRANT_W'(i));
        end
    end

    // First valid requester at or after rr_ptr, wrapping through N_REQ-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_ptr;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = rr_ptr + GRANT_W'(i);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
            last_reg <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            grant_id <= '0;
            active   <= 1'b0;
            lock_err <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            gap_cnt  <= gap_nxt;
            tmo_cnt  <= tmo_nxt;
            last_reg <= last_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
            grant_id <= grant_nxt;
            active   <= active_nxt;
            lock_err <= lock_err_nxt;
            ack_err  <= ack_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (win_found) state_nxt = LOAD;
            LOAD: begin
                if (handshake)         state_nxt = START;
                else if (lock_expired) state_nxt = IDLE;
            end
            START:     state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy)          state_nxt = WAIT_DONE;
                else if (ack_expired) state_nxt = GAP;
            end
            WAIT_DONE: if (!tx_busy) state_nxt = GAP;
            GAP:       if (gap_expired) state_nxt = last_reg ? IDLE : LOAD;
            default:   state_nxt = IDLE;
        endcase
    end

    // Counters clear by default so every state is entered with a zero count.
    always_comb begin
        rr_nxt       = rr_ptr;
        gap_nxt      = '0;
        tmo_nxt      = '0;
        last_nxt     = last_reg;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        grant_nxt    = grant_id;
        active_nxt   = active;
        lock_err_nxt = 1'b0;
        ack_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nxt  = win_id;
                    active_nxt = 1'b1;
                end
            end
            LOAD: begin
                if (handshake) begin
                    tx_data_nxt  = sel_data;
                    last_nxt     = req_last[grant_id];
                    tx_start_nxt = 1'b1;
                end else if (lock_expired) begin
                    lock_err_nxt = 1'b1;
                    active_nxt   = 1'b0;
                    rr_nxt       = grant_id + 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            // The start cycle counts toward the acknowledge window.
            START: tmo_nxt = tmo_cnt + 1'b1;
            WAIT_ACK: begin
                if (!tx_busy) begin
                    if (ack_expired) ack_err_nxt = 1'b1;
                    else             tmo_nxt     = tmo_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_expired) begin
                    if (last_reg) begin
                        active_nxt = 1'b0;
                        rr_nxt     = grant_id + 1'b1;
                    end
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected (grant, byte) pairs are queued with the
// stimulus and popped on every tx_start; timeout and reset behaviour are checked per test.
module tb_uart_tx_arbiter;
    localparam int LOCK_T = 100;
    localparam int ACK_T  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active, lock_err, ack_err;

    uart_tx_arbiter #(
        .GRANT_W(2), .GAP_CYCLES(0), .LOCK_TIMEOUT(LOCK_T), .ACK_TIMEOUT(ACK_T)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
        .active(active), .lock_err(lock_err), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for 10 clocks after each start unless disabled.
    int   busy_cnt = 0;
    logic tx_en = 1'b1;
    always @(posedge clk) begin
        if (rst)                     busy_cnt <= 0;
        else if (tx_start && tx_en)  busy_cnt <= 10;
        else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    logic [8:0] rq_mem [4][8];
    int         rq_cnt [4];
    int         rq_head[4];
    logic [9:0] exp_q[$];

    int   n_checks = 0, n_pass = 0;
    int   n_start = 0, n_lock = 0, n_ack = 0;
    int   cyc = 0, start_cyc = 0, ack_gap = -1, run3 = 0, lock_run = -1;
    logic lock_active = 1'bx;
    logic mon_en = 1'b0;

    always @(negedge clk) begin
        logic [9:0] e;
        if (mon_en && !rst) begin
            cyc++;
            if (lock_err === 1'b1) begin
                n_lock++;
                lock_run    = run3;
                lock_active = active;
            end
            if (req_ready[3] === 1'b1) run3++; else run3 = 0;
            if (ack_err === 1'b1) begin
                n_ack++;
                ack_gap = cyc - start_cyc;
            end
            if (tx_start === 1'b1) begin
                n_start++;
                start_cyc = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected_start got grant=%0d data=%h want none", grant_id, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant_id, tx_data} !== e)
                        $display("FAIL sb_byte got grant=%0d data=%h want grant=%0d data=%h",
                                 grant_id, tx_data, e[9:8], e[7:0]);
                    else n_pass++;
                end
            end
            if (req_ready !== 4'b0000) begin
                n_checks++;
                if (req_ready !== (4'b0001 << grant_id))
                    $display("FAIL ready_onehot got %b want %b", req_ready, 4'b0001 << grant_id);
                else n_pass++;
            end
        end
    end

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (rq_head[i] < rq_cnt[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = rq_mem[i][rq_head[i]][7:0];
                req_last[i]         = rq_mem[i][rq_head[i]][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [3:0] hs;
        @(negedge clk);
        hs = rst ? 4'b0000 : (req_valid & req_ready);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (hs[i]) rq_head[i]++;
        drive_inputs();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 4; i++) begin
            rq_cnt[i]  = 0;
            rq_head[i] = 0;
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic l);
        rq_mem[r][rq_cnt[r]] = {l, d};
        rq_cnt[r]++;
    endtask

    task automatic expect_byte(input int g, input logic [7:0] d);
        logic [1:0] gi;
        gi = g[1:0];
        exp_q.push_back({gi, d});
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        tx_en = 1'b1;
        clear_reqs();
        exp_q.delete();
        drive_inputs();
        step();
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while ((exp_q.size() != 0 || active !== 1'b0) && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({tx_start, tx_data, req_ready, grant_id} !== 15'h0)
            $display("FAIL reset_datapath got %h want 0", {tx_start, tx_data, req_ready, grant_id});
        else n_pass++;
        n_checks++;
        if ({active, lock_err, ack_err} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {active, lock_err, ack_err});
        else n_pass++;
    endtask

    task automatic test_single();
        int n, s0;
        do_reset();
        s0 = n_start;
        add_byte(1, 8'h41, 1'b0); add_byte(1, 8'h42, 1'b0); add_byte(1, 8'h43, 1'b1);
        expect_byte(1, 8'h41); expect_byte(1, 8'h42); expect_byte(1, 8'h43);
        drive_inputs();
        step();
        n_checks++;
        if ({req_ready, grant_id, active} !== {4'b0010, 2'd1, 1'b1})
            $display("FAIL single_grant_lat got ready=%b grant=%0d active=%b want 0010/1/1", req_ready, grant_id, active);
        else n_pass++;
        step();
        n_checks++;
        if ({tx_start, tx_data} !== {1'b1, 8'h41})
            $display("FAIL single_start_lat got start=%b data=%h want 1/41", tx_start, tx_data);
        else n_pass++;
        wait_done(300, n);
        n_checks++;
        if (n >= 300 || n_start - s0 != 3 || grant_id !== 2'd1)
            $display("FAIL single_done got cycles=%0d starts=%0d grant=%0d want <300/3/1", n, n_start - s0, grant_id);
        else n_pass++;
        // rr_ptr should now be 2, so requester 2 beats requester 1.
        add_byte(1, 8'h44, 1'b1); add_byte(2, 8'h62, 1'b1);
        expect_byte(2, 8'h62); expect_byte(1, 8'h44);
        drive_inputs();
        wait_done(300, n);
        n_checks++;
        if (n >= 300) $display("FAIL single_rr_next got timeout=%0d want <300", n);
        else n_pass++;
    endtask

    task automatic test_two_msgs();
        int n;
        do_reset();
        add_byte(0, 8'hA0, 1'b0); add_byte(0, 8'hA1, 1'b1);
        add_byte(2, 8'hC0, 1'b0); add_byte(2, 8'hC1, 1'b1);
        expect_byte(0, 8'hA0); expect_byte(0, 8'hA1);
        expect_byte(2, 8'hC0); expect_byte(2, 8'hC1);
        drive_inputs();
        wait_done(300, n);
        n_checks++;
        if (n >= 300) $display("FAIL two_msgs got timeout=%0d want <300", n);
        else n_pass++;
        // rr_ptr = 3: requester 3 goes before requester 0.
        add_byte(0, 8'hA2, 1'b1); add_byte(3, 8'hD3, 1'b1);
        expect_byte(3, 8'hD3); expect_byte(0, 8'hA2);
        drive_inputs();
        wait_done(300, n);
        n_checks++;
        if (n >= 300) $display("FAIL two_msgs_rr got timeout=%0d want <300", n);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n, s0;
        do_reset();
        s0 = n_start;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                add_byte(i, 8'(8'h10 * k + i), 1'b1);
                expect_byte(i, 8'(8'h10 * k + i));
            end
        drive_inputs();
        wait_done(600, n);
        n_checks++;
        if (n >= 600 || n_start - s0 != 8)
            $display("FAIL b2b_count got cycles=%0d starts=%0d want <600/8", n, n_start - s0);
        else n_pass++;
    endtask

    task automatic test_lock_timeout();
        int n, l0;
        do_reset();
        l0 = n_lock;
        add_byte(3, 8'h33, 1'b0);
        expect_byte(3, 8'h33);
        drive_inputs();
        repeat (5) step();
        add_byte(0, 8'h0A, 1'b1);
        expect_byte(0, 8'h0A);
        drive_inputs();
        wait_done(400, n);
        n_checks++;
        if (n >= 400 || n_lock - l0 != 1)
            $display("FAIL lock_pulse got cycles=%0d pulses=%0d want <400/1", n, n_lock - l0);
        else n_pass++;
        n_checks++;
        if (lock_run != LOCK_T || lock_active !== 1'b0)
            $display("FAIL lock_timing got load_cycles=%0d active=%b want %0d/0", lock_run, lock_active, LOCK_T);
        else n_pass++;
    endtask

    task automatic test_ack_timeout();
        int n, a0, s0;
        do_reset();
        tx_en = 1'b0;
        a0 = n_ack;
        s0 = n_start;
        add_byte(1, 8'h51, 1'b0); add_byte(1, 8'h52, 1'b1);
        expect_byte(1, 8'h51); expect_byte(1, 8'h52);
        drive_inputs();
        wait_done(300, n);
        n_checks++;
        if (n >= 300 || n_ack - a0 != 2 || n_start - s0 != 2)
            $display("FAIL ack_count got cycles=%0d acks=%0d starts=%0d want <300/2/2", n, n_ack - a0, n_start - s0);
        else n_pass++;
        n_checks++;
        if (ack_gap != ACK_T) $display("FAIL ack_timing got %0d want %0d", ack_gap, ACK_T);
        else n_pass++;
        tx_en = 1'b1;
    endtask

    task automatic test_reset_in_gap();
        int n, s0;
        do_reset();
        add_byte(1, 8'h71, 1'b1);
        expect_byte(1, 8'h71);
        drive_inputs();
        wait_done(300, n);
        add_byte(2, 8'h81, 1'b0); add_byte(2, 8'h82, 1'b1);
        expect_byte(2, 8'h81);
        drive_inputs();
        s0 = n_start;
        n  = 0;
        while (n_start == s0 && n < 50) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= 50) $display("FAIL gap_rst_start got timeout=%0d want <50", n);
        else n_pass++;
        // Start was in cycle S; we are now in S+1 and GAP falls in S+12.
        repeat (11) step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({tx_start, tx_data, req_ready, grant_id, active, lock_err, ack_err} !== 18'h0)
            $display("FAIL gap_rst_outputs got %h want 0",
                     {tx_start, tx_data, req_ready, grant_id, active, lock_err, ack_err});
        else n_pass++;
        rst = 1'b0;
        clear_reqs();
        exp_q.delete();
        add_byte(0, 8'h90, 1'b1); add_byte(3, 8'h93, 1'b1);
        expect_byte(0, 8'h90); expect_byte(3, 8'h93);
        drive_inputs();
        wait_done(300, n);
        n_checks++;
        if (n >= 300) $display("FAIL gap_rst_fresh got timeout=%0d want <300", n);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got time=%0t want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_reqs();
        test_reset();
        test_single();
        test_two_msgs();
        test_back_to_back();
        test_lock_timeout();
        test_ack_timeout();
        test_reset_in_gap();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
